dft_bin_sched: RTL and testbench

DFT_BIN_SCHED -- requirements
Module: dft_bin_sched

---
 rtl/dft_bin_sched.sv | 208 ++++++++++++++++++++
 tb/tb_dft_bin_sched.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dft_bin_sched.sv
// rtl/dft_bin_sched.sv - round-robin scheduler sharing one single-bin DFT engine over a bin table
// Optional DFT_SCHED_MAG_EN adds r_mag = r_re^2 + r_im^2 through a 2-cycle pipeline.
module dft_bin_sched #(
  parameter int N        = 1024,
  parameter int NUM_BINS = 4,
  parameter int KW       = 10,
  parameter int DW       = 16,
  parameter int RW       = 40,
  parameter int TMO      = 64
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        en,
  input  logic                        cfg_we,
  input  logic [$clog2(NUM_BINS)-1:0] cfg_addr,
  input  logic [KW-1:0]               cfg_k,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic signed [DW-1:0]        s_data,
  output logic                        eng_clr,
  output logic [KW-1:0]               eng_k,
  output logic                        eng_valid,
  output logic [DW-1:0]               eng_x,
  input  logic                        eng_done,
  input  logic signed [RW-1:0]        eng_re,
  input  logic signed [RW-1:0]        eng_im,
  output logic                        r_valid,
  input  logic                        r_ready,
  output logic [KW-1:0]               r_bin,
  output logic signed [RW-1:0]        r_re,
  output logic signed [RW-1:0]        r_im,
`ifdef DFT_SCHED_MAG_EN
  output logic [2*RW:0]               r_mag,
`endif
  output logic                        busy,
  output logic                        err
);

  localparam int AW = $clog2(NUM_BINS);
  localparam int CW = $clog2(N);
  localparam int TW = $clog2(TMO + 1);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_FEED, ST_WAIT, ST_OUT} state_t;

  state_t                state_q;
  logic [KW-1:0]         tbl_q [NUM_BINS];
  logic [AW-1:0]         idx_q;
  logic [AW-1:0]         idx_d;
  logic [CW-1:0]         cnt_q;
  logic [TW-1:0]         tmo_q;
  logic                  s_ready_q, eng_clr_q, eng_valid_q, r_valid_q, busy_q, err_q;
  logic [KW-1:0]         eng_k_q, r_bin_q;
  logic [DW-1:0]         eng_x_q;
  logic signed [RW-1:0]  r_re_q, r_im_q;
  logic signed [RW-1:0]  cap_re, cap_im;
  logic                  tmo_hit, wait_hit;

  assign idx_d   = idx_q + 1'b1;
  assign tmo_hit = (tmo_q == TW'(TMO - 1));
  // A timeout captures zeros through the same path as a real result.
  assign cap_re  = eng_done ? eng_re : '0;
  assign cap_im  = eng_done ? eng_im : '0;

`ifdef DFT_SCHED_MAG_EN
  logic cap_q;
  assign wait_hit = (state_q == ST_WAIT) && !cap_q && (eng_done || tmo_hit);
`else
  assign wait_hit = (state_q == ST_WAIT) && (eng_done || tmo_hit);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_BINS; i++) tbl_q[i] <= KW'(i + 1);
    end else if (cfg_we) begin
      tbl_q[cfg_addr] <= cfg_k;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      s_ready_q   <= 1'b0;
      eng_clr_q   <= 1'b0;
      eng_valid_q <= 1'b0;
      r_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      eng_k_q     <= '0;
      eng_x_q     <= '0;
      r_bin_q     <= '0;
      r_re_q      <= '0;
      r_im_q      <= '0;
`ifdef DFT_SCHED_MAG_EN
      cap_q       <= 1'b0;
`endif
    end else begin
      eng_valid_q <= 1'b0;
      eng_clr_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (en) begin
            state_q   <= ST_START;
            busy_q    <= 1'b1;
            eng_clr_q <= 1'b1;
            eng_k_q   <= tbl_q[idx_q];
          end
        end
        ST_START: begin
          state_q   <= ST_FEED;
          cnt_q     <= '0;
          s_ready_q <= 1'b1;
        end
        ST_FEED: begin
          if (s_valid) begin
            eng_valid_q <= 1'b1;
            eng_x_q     <= s_data;
            cnt_q       <= cnt_q + 1'b1;
            if (cnt_q == CW'(N - 1)) begin
              s_ready_q <= 1'b0;
              tmo_q     <= '0;
              state_q   <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
`ifdef DFT_SCHED_MAG_EN
          if (cap_q) begin
            cap_q     <= 1'b0;
            r_valid_q <= 1'b1;
            state_q   <= ST_OUT;
          end else
`endif
          if (wait_hit) begin
            r_bin_q <= eng_k_q;
            r_re_q  <= cap_re;
            r_im_q  <= cap_im;
            if (!eng_done) err_q <= 1'b1;
`ifdef DFT_SCHED_MAG_EN
            cap_q     <= 1'b1;
`else
            r_valid_q <= 1'b1;
            state_q   <= ST_OUT;
`endif
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_OUT: begin
          if (r_ready) begin
            r_valid_q <= 1'b0;
            idx_q     <= idx_d;
            if (en) begin
              state_q   <= ST_START;
              eng_clr_q <= 1'b1;
              eng_k_q   <= tbl_q[idx_d];
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DFT_SCHED_MAG_EN
  localparam int PW = 2 * RW;
  logic [PW-1:0] sq_re_q, sq_im_q;
  logic [PW:0]   r_mag_q;

  // Squares load with the capture; the sum settles one cycle later, as OUT begins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sq_re_q <= '0;
      sq_im_q <= '0;
      r_mag_q <= '0;
    end else begin
      if (wait_hit) begin
        sq_re_q <= PW'(cap_re) * PW'(cap_re);
        sq_im_q <= PW'(cap_im) * PW'(cap_im);
      end
      r_mag_q <= {1'b0, sq_re_q} + {1'b0, sq_im_q};
    end
  end

  assign r_mag = r_mag_q;
`endif

  assign s_ready   = s_ready_q;
  assign eng_clr   = eng_clr_q;
  assign eng_k     = eng_k_q;
  assign eng_valid = eng_valid_q;
  assign eng_x     = eng_x_q;
  assign r_valid   = r_valid_q;
  assign r_bin     = r_bin_q;
  assign r_re      = r_re_q;
  assign r_im      = r_im_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dft_bin_sched.sv
// tb/tb_dft_bin_sched.sv - self-checking bench for dft_bin_sched with a behavioural engine and frame model
module tb_dft_bin_sched;
  localparam int N = 16, NB = 2, KW = 10, DW = 16, RW = 40, TMO = 8;
`ifdef DFT_SCHED_MAG_EN
  localparam int MAGX = 1;
`else
  localparam int MAGX = 0;
`endif

  logic clk = 1'b0;
  logic rstn, en, cfg_we;
  logic [0:0] cfg_addr;
  logic [KW-1:0] cfg_k;
  logic s_valid, s_ready;
  logic signed [DW-1:0] s_data;
  logic eng_clr, eng_valid, eng_done;
  logic [KW-1:0] eng_k;
  logic [DW-1:0] eng_x;
  logic signed [RW-1:0] eng_re, eng_im;
  logic r_valid, r_ready, busy, err;
  logic [KW-1:0] r_bin;
  logic [RW-1:0] r_re, r_im;
`ifdef DFT_SCHED_MAG_EN
  logic [2*RW:0] r_mag;
`endif

  always #5 clk = ~clk;

  dft_bin_sched #(.N(N), .NUM_BINS(NB), .KW(KW), .DW(DW), .RW(RW), .TMO(TMO)) dut (
    .clk(clk), .rstn(rstn), .en(en),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_k(cfg_k),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .eng_clr(eng_clr), .eng_k(eng_k), .eng_valid(eng_valid), .eng_x(eng_x),
    .eng_done(eng_done), .eng_re(eng_re), .eng_im(eng_im),
    .r_valid(r_valid), .r_ready(r_ready), .r_bin(r_bin), .r_re(r_re), .r_im(r_im),
`ifdef DFT_SCHED_MAG_EN
    .r_mag(r_mag),
`endif
    .busy(busy), .err(err)
  );

  typedef struct {
    int mode;      // 0 continuous, 1 toggling, 2 random s_valid
    int hold;      // cycles r_ready held low in OUT
    bit hang;      // engine never answers
    bit spur;      // engine emits a stray eng_done during FEED
    bit cfg;
    int cfg_addr;
    int cfg_val;
    int cfg_beat;
    bit drop_en;
    int exp_k;
    bit exp_err;
  } vec_t;

  int checks = 0, errors = 0;
  int model_tbl [NB];
  int midx;
  bit m_err;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Engine: accumulate the frame, answer 3 cycles after the N-th beat.
  bit eng_hang = 0, eng_spur = 0;
  longint e_acc;
  int e_beats, e_pend, e_k, clr_len, clr_k;
  bit prev_clr;
  initial begin
    eng_done = 0; eng_re = 0; eng_im = 0;
    e_acc = 0; e_beats = 0; e_pend = 0; e_k = 0; clr_len = 0; clr_k = 0; prev_clr = 0;
    forever begin
      tick;
      eng_done = 0;
      if (e_pend > 0) begin
        e_pend--;
        if (e_pend == 0) begin
          eng_done = 1;
          eng_re = RW'(e_acc);
          eng_im = RW'(e_acc * e_k);
        end
      end
      if (eng_clr) begin
        clr_len = prev_clr ? clr_len + 1 : 1;
        clr_k = int'(eng_k);
        e_k = int'(eng_k);
        e_acc = 0; e_beats = 0; e_pend = 0;
      end
      prev_clr = eng_clr;
      if (eng_valid) begin
        e_acc += longint'($signed(eng_x));
        e_beats++;
        if (e_beats == N && !eng_hang) e_pend = 3;
        if (eng_spur && e_beats == 4) begin
          eng_done = 1;
          eng_re = 12345;
          eng_im = -77;
        end
      end
    end
  end

  task automatic run_frame(input vec_t v);
    int k, nacc, cyc, vbad, leak, stab, bad;
    bit rdy, vld, cfg_done, err_prev;
    logic signed [DW-1:0] d;
    longint sum, exp_re, exp_im;
    logic [RW-1:0] h_re, h_im;
    logic [KW-1:0] h_bin;
    err_prev = m_err;
    eng_hang = v.hang;
    eng_spur = v.spur;
    s_valid = 0;
    k = 0;
    while (!s_ready && k < 20) begin tick; k++; end
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL feed_entry: s_ready=%0b after %0d cycles, expected 1", s_ready, k);
      return;
    end
    chk("eng_clr_k", clr_k, v.exp_k);
    chk("eng_clr_len", clr_len, 1);

    sum = 0; nacc = 0; cyc = 0; vbad = 0; cfg_done = 0;
    while (nacc < N && cyc < 200) begin
      case (v.mode)
        0: s_valid = 1;
        1: s_valid = (cyc % 2 == 0);
        default: s_valid = ($urandom_range(0, 99) < 60);
      endcase
      s_data = DW'($urandom);
      if (v.cfg && !cfg_done && nacc == v.cfg_beat) begin
        cfg_we = 1; cfg_addr = 1'(v.cfg_addr); cfg_k = KW'(v.cfg_val);
        model_tbl[v.cfg_addr] = v.cfg_val;
        cfg_done = 1;
      end
      if (v.drop_en && nacc == 8) en = 0;
      rdy = s_ready; vld = s_valid; d = s_data;
      tick;
      cyc++;
      cfg_we = 0;
      if (eng_valid !== (vld && rdy) || (vld && rdy && eng_x !== d)) vbad++;
      if (vld && rdy) begin sum += d; nacc++; end
    end
    if (nacc < N) begin
      checks++; errors++;
      $display("FAIL feed_beats: accepted %0d beats, expected %0d", nacc, N);
      return;
    end
    chk("eng_valid_timing", vbad, 0);

    leak = 0; k = 0;
    s_valid = 1;
    while (!r_valid && k < 40) begin
      if (s_ready || (k > 0 && eng_valid)) leak++;
      s_data = DW'($urandom);
      tick;
      k++;
      if (v.hang && !err_prev && k == TMO - 1) chk("err_before_tmo", err, 0);
    end
    if (!r_valid) begin
      checks++; errors++;
      $display("FAIL r_valid_wait: r_valid=%0b after %0d cycles, expected 1", r_valid, k);
      return;
    end
    exp_re = v.hang ? 0 : sum;
    exp_im = v.hang ? 0 : sum * v.exp_k;
    chk("r_latency", k, (v.hang ? TMO : 4) + MAGX);
    chk("err_flag", err, v.exp_err);
    if (!v.hang) chk("r_bin", r_bin, v.exp_k);
    if (!v.hang) chk("eng_beats", e_beats, N);
    chk("r_re", longint'($signed(r_re)), exp_re);
    chk("r_im", longint'($signed(r_im)), exp_im);
`ifdef DFT_SCHED_MAG_EN
    chk("r_mag", longint'(r_mag), exp_re * exp_re + exp_im * exp_im);
`endif

    h_re = r_re; h_im = r_im; h_bin = r_bin; stab = 0;
    r_ready = 0;
    for (int h = 0; h < v.hold; h++) begin
      tick;
      if (!r_valid || r_re !== h_re || r_im !== h_im || r_bin !== h_bin || s_ready) stab++;
    end
    if (v.hold > 0) chk("hold_stable", stab, 0);
    r_ready = 1;
    tick;
    r_ready = 0;
    s_valid = 0;
    chk("s_ready_leak", leak, 0);
    chk("r_valid_drop", r_valid, 0);
    midx = (midx + 1) % NB;
    if (v.hang) m_err = 1;
    if (v.drop_en) begin
      chk("idle_busy", busy, 0);
      bad = 0;
      repeat (3) begin
        tick;
        if (busy || s_ready || eng_clr) bad++;
      end
      chk("idle_hold", bad, 0);
      en = 1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vt [9];
  vec_t rv;

  initial begin
    rstn = 0; en = 0; cfg_we = 0; cfg_addr = 0; cfg_k = 0;
    s_valid = 0; s_data = 0; r_ready = 0;
    model_tbl[0] = 1; model_tbl[1] = 2; midx = 0; m_err = 0;

    vt[0] = '{0, 0,  0, 0, 0, 0, 0,   0,  0, 1,   0};
    vt[1] = '{0, 2,  0, 0, 0, 0, 0,   0,  0, 2,   0};
    vt[2] = '{1, 0,  0, 1, 0, 0, 0,   0,  0, 1,   0};
    vt[3] = '{1, 10, 0, 0, 0, 0, 0,   0,  0, 2,   0};
    vt[4] = '{2, 0,  0, 0, 1, 0, 37,  5,  0, 1,   0};
    vt[5] = '{0, 1,  0, 0, 1, 1, 500, 10, 0, 2,   0};
    vt[6] = '{2, 3,  1, 0, 0, 0, 0,   0,  0, 37,  1};
    vt[7] = '{0, 0,  0, 0, 0, 0, 0,   0,  0, 500, 1};
    vt[8] = '{2, 2,  0, 1, 0, 0, 0,   0,  1, 37,  1};

    #22;
    chk("rst_ctrl", {busy, s_ready, eng_clr, eng_valid, r_valid, err}, 0);
    chk("rst_data", {eng_k, eng_x, r_bin, r_re, r_im} != 0, 0);
    @(negedge clk);
    rstn = 1;
    tick; tick;
    chk("idle_no_en", busy, 0);
    en = 1;

    for (int i = 0; i < 9; i++) run_frame(vt[i]);

    for (int i = 0; i < 10; i++) begin
      rv.mode = 2;
      rv.hold = $urandom_range(0, 4);
      rv.hang = 0;
      rv.spur = 1'($urandom_range(0, 1));
      rv.cfg = 1'($urandom_range(0, 1));
      rv.cfg_addr = $urandom_range(0, NB - 1);
      rv.cfg_val = $urandom_range(1, 1023);
      rv.cfg_beat = $urandom_range(0, N - 1);
      rv.drop_en = 0;
      rv.exp_k = model_tbl[midx];
      rv.exp_err = m_err;
      run_frame(rv);
    end

    // Reset in the middle of a frame: partial frame dropped, table and err restored.
    eng_hang = 0; eng_spur = 0;
    for (int k = 0; k < 20 && !s_ready; k++) tick;
    s_valid = 1;
    repeat (5) tick;
    #2;
    rstn = 0;
    #1;
    chk("async_rst", {busy, s_ready, eng_valid, err, r_valid}, 0);
    s_valid = 0;
    @(negedge clk);
    rstn = 1;
    model_tbl[0] = 1; model_tbl[1] = 2; midx = 0; m_err = 0;
    rv = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    run_frame(rv);
    rv = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0};
    run_frame(rv);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
